// File: rtl/i2c_od_pio.sv
// i2c_od_pio: Avalon-MM PIO with per-bit direction, open-drain drive, synchronized readback and edge-capture irq
module i2c_od_pio #(
  parameter int          WIDTH       = 2,
  parameter logic [31:0] RESET_DATA  = 32'h3,
  parameter int          OPEN_DRAIN  = 1,
  parameter int          EDGE_TYPE   = 2,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic             irq
);
  localparam int CW = $clog2(SYNC_STAGES + 2);
  logic [SYNC_STAGES*WIDTH-1:0] sync_r;
  logic [WIDTH-1:0] sync, prev_r, data_r, dir_r, irqmask_r, edgecap_r;
  logic [WIDTH-1:0] wd, rise, fall, det, clr;
  logic [CW-1:0] arm_cnt;
  logic armed, we, unused;
  assign unused = ^writedata;
  assign wd     = writedata[WIDTH-1:0];
  assign we     = chipselect & ~write_n;
  assign sync   = sync_r[SYNC_STAGES*WIDTH-1 -: WIDTH];
  assign armed  = arm_cnt == CW'(SYNC_STAGES + 1);
  assign rise   = sync & ~prev_r;
  assign fall   = ~sync & prev_r;
  assign det    = !armed ? '0 : EDGE_TYPE == 0 ? rise : EDGE_TYPE == 1 ? fall : rise | fall;
  assign clr    = (we && address == 3'd3) ? wd : '0;
  assign pad_out = OPEN_DRAIN != 0 ? '0 : data_r;
  assign pad_oe  = OPEN_DRAIN != 0 ? dir_r & ~data_r : dir_r;
  assign irq     = |(edgecap_r & irqmask_r);
  assign readdata = address == 3'd0 ? 32'(sync) :
                    address == 3'd1 ? 32'(dir_r) :
                    address == 3'd2 ? 32'(irqmask_r) :
                    address == 3'd3 ? 32'(edgecap_r) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r    <= '0;
      prev_r    <= '0;
      arm_cnt   <= '0;
      data_r    <= RESET_DATA[WIDTH-1:0];
      dir_r     <= '0;
      irqmask_r <= '0;
      edgecap_r <= '0;
    end else begin
      sync_r  <= {sync_r[(SYNC_STAGES-1)*WIDTH-1:0], pad_in};
      prev_r  <= sync;
      arm_cnt <= armed ? arm_cnt : arm_cnt + 1'b1;
      if (we && address == 3'd0) data_r <= wd;
      else if (we && address == 3'd4) data_r <= data_r | wd;
      else if (we && address == 3'd5) data_r <= data_r & ~wd;
      if (we && address == 3'd1) dir_r <= wd;
      if (we && address == 3'd2) irqmask_r <= wd;
      // a fresh edge outranks a simultaneous write-1-clear
      edgecap_r <= (edgecap_r & ~clr) | det;
    end
  end
endmodule

// File: tb/tb_i2c_od_pio.sv
// tb_i2c_od_pio: open-drain/any-edge and push-pull/rising-edge instances against a sample-history model
module tb_i2c_od_pio;
  localparam int S = 2;
  logic clk = 0, reset = 1, chipselect = 0, write_n = 1;
  logic [2:0] address = 0;
  logic [31:0] writedata = 0, readdata_a, readdata_b;
  logic [1:0] pad_in = 2'b11, pad_out_a, pad_oe_a, pad_out_b, pad_oe_b;
  logic irq_a, irq_b;
  int n_checks = 0, n_fail = 0;
  logic [1:0] m_data, m_dir, m_mask, m_cap_a, m_cap_b;
  logic [1:0] hist[$];

  always #5 clk = ~clk;

  i2c_od_pio #(.WIDTH(2), .RESET_DATA(32'h3), .OPEN_DRAIN(1), .EDGE_TYPE(2), .SYNC_STAGES(S)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata_a), .pad_in(pad_in), .pad_out(pad_out_a),
    .pad_oe(pad_oe_a), .irq(irq_a));
  i2c_od_pio #(.WIDTH(2), .RESET_DATA(32'h3), .OPEN_DRAIN(0), .EDGE_TYPE(0), .SYNC_STAGES(S)) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata_b), .pad_in(pad_in), .pad_out(pad_out_b),
    .pad_oe(pad_oe_b), .irq(irq_b));

  // p(j): pad value sampled at the j-th clock edge since reset released (0 before that)
  function automatic logic [1:0] p(input int j);
    return (j >= 1 && j <= hist.size()) ? hist[j-1] : 2'b00;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] a, input logic [1:0] cap);
    return a == 0 ? {30'd0, p(hist.size() - S + 1)} : a == 1 ? {30'd0, m_dir} :
           a == 2 ? {30'd0, m_mask} : a == 3 ? {30'd0, cap} : 32'd0;
  endfunction

  task automatic tick();
    logic [1:0] s, pv, r, f, wd;
    int k;
    @(posedge clk);
    if (reset) begin
      m_data = 2'b11; m_dir = 0; m_mask = 0; m_cap_a = 0; m_cap_b = 0;
      hist.delete();
    end else begin
      hist.push_back(pad_in);
      k = hist.size();
      r = 0; f = 0;
      // only compare two genuine post-reset synchronized samples
      if (k >= S + 2) begin
        s = p(k - S); pv = p(k - S - 1);
        r = s & ~pv; f = ~s & pv;
      end
      wd = writedata[1:0];
      if (chipselect && !write_n)
        case (address)
          3'd0: m_data = wd;
          3'd1: m_dir = wd;
          3'd2: m_mask = wd;
          3'd3: begin m_cap_a = m_cap_a & ~wd; m_cap_b = m_cap_b & ~wd; end
          3'd4: m_data = m_data | wd;
          3'd5: m_data = m_data & ~wd;
          default: ;
        endcase
      m_cap_a = m_cap_a | r | f;
      m_cap_b = m_cap_b | r;
    end
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    tick();
    chipselect = 0; write_n = 1;
  endtask

  task automatic test_reset();
    reset = 1; pad_in = 2'b11;
    repeat (3) tick();
    reset = 0;
    n_checks++;
    if (pad_oe_a !== 2'b00 || irq_a !== 1'b0 || pad_out_a !== 2'b00) begin
      n_fail++; $display("FAIL reset_a: oe=%b irq=%b out=%b want oe=00 irq=0 out=00", pad_oe_a, irq_a, pad_out_a);
    end
    n_checks++;
    if (pad_oe_b !== 2'b00 || pad_out_b !== 2'b11 || irq_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_b: oe=%b out=%b irq=%b want oe=00 out=11 irq=0", pad_oe_b, pad_out_b, irq_b);
    end
    address = 0;
    tick(); tick();
    n_checks++;
    if (readdata_a !== 32'h3) begin n_fail++; $display("FAIL reset_data_read: got %h want 3", readdata_a); end
    address = 3;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (readdata_a !== 0 || readdata_b !== 0) begin
        n_fail++; $display("FAIL no_false_edge[%0d]: a=%h b=%h want 0", i, readdata_a, readdata_b);
      end
      tick();
    end
  endtask

  task automatic test_set_clr();
    wr(1, 3); wr(5, 1);
    n_checks++;
    if (pad_oe_a !== 2'b01) begin n_fail++; $display("FAIL outclr_oe: got %b want 01", pad_oe_a); end
    wr(4, 1);
    n_checks++;
    if (pad_oe_a !== 2'b00) begin n_fail++; $display("FAIL outset_oe: got %b want 00", pad_oe_a); end
    pad_in = 2'b10; address = 0;
    tick();
    n_checks++;
    if (readdata_a !== 32'h3) begin n_fail++; $display("FAIL data_read_lag: got %h want 3", readdata_a); end
    tick();
    n_checks++;
    if (readdata_a !== 32'h2) begin n_fail++; $display("FAIL data_read_pad: got %h want 2", readdata_a); end
  endtask

  task automatic test_edge_irq();
    repeat (3) tick();
    wr(3, 3); wr(2, 2);
    address = 3; #1;
    n_checks++;
    if (readdata_a !== 0 || irq_a !== 0) begin n_fail++; $display("FAIL cap_cleared: got %h irq=%b want 0", readdata_a, irq_a); end
    pad_in = 2'b00;
    tick(); tick();
    n_checks++;
    if (readdata_a[1] !== 1'b0 || irq_a !== 1'b0) begin n_fail++; $display("FAIL cap_early: cap=%h irq=%b want bit1=0", readdata_a, irq_a); end
    tick();
    n_checks++;
    if (readdata_a[1] !== 1'b1 || irq_a !== 1'b1) begin n_fail++; $display("FAIL cap_fall: cap=%h irq=%b want bit1=1 irq=1", readdata_a, irq_a); end
    n_checks++;
    if (readdata_b[1] !== 1'b0 || irq_b !== 1'b0) begin n_fail++; $display("FAIL rise_only_b: cap=%h irq=%b want bit1=0", readdata_b, irq_b); end
    wr(3, 2);
    n_checks++;
    if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq_a); end
  endtask

  task automatic test_set_wins();
    pad_in = 2'b10;
    tick(); tick();
    wr(3, 2);
    address = 3; #1;
    n_checks++;
    if (readdata_a[1] !== 1'b1 || irq_a !== 1'b1) begin n_fail++; $display("FAIL set_wins_a: cap=%h irq=%b want bit1=1 irq=1", readdata_a, irq_a); end
    n_checks++;
    if (readdata_b[1] !== 1'b1 || irq_b !== 1'b1) begin n_fail++; $display("FAIL set_wins_b: cap=%h irq=%b want bit1=1 irq=1", readdata_b, irq_b); end
  endtask

  task automatic test_push_pull();
    wr(1, 3); wr(0, 2);
    n_checks++;
    if (pad_out_b !== 2'b10 || pad_oe_b !== 2'b11) begin n_fail++; $display("FAIL pp_drive: out=%b oe=%b want 10 11", pad_out_b, pad_oe_b); end
    n_checks++;
    if (pad_out_a !== 2'b00 || pad_oe_a !== 2'b01) begin n_fail++; $display("FAIL od_drive: out=%b oe=%b want 00 01", pad_out_a, pad_oe_a); end
    for (int a = 4; a < 8; a++) begin
      address = 3'(a); #1;
      n_checks++;
      if (readdata_b !== 0 || readdata_a !== 0) begin n_fail++; $display("FAIL read_zero[%0d]: a=%h b=%h want 0", a, readdata_a, readdata_b); end
    end
    address = 1; #1;
    n_checks++;
    if (readdata_b !== 32'h3) begin n_fail++; $display("FAIL dir_read: got %h want 3", readdata_b); end
    wr(0, 32'hFFFF_FFFC);
    n_checks++;
    if (pad_out_b !== 2'b00) begin n_fail++; $display("FAIL upper_ignored: got %b want 00", pad_out_b); end
  endtask

  task automatic test_mid_reset();
    pad_in = 2'b11; repeat (4) tick();
    pad_in = 2'b10; repeat (4) tick();
    wr(1, 3); wr(2, 3);
    address = 3; #1;
    n_checks++;
    if (readdata_a !== 32'h3 || irq_a !== 1'b1) begin n_fail++; $display("FAIL pre_reset_cap: got %h irq=%b want 3 irq=1", readdata_a, irq_a); end
    reset = 1; chipselect = 1; write_n = 0; address = 5; writedata = 3;
    tick();
    reset = 0; chipselect = 0; write_n = 1; address = 3; #1;
    n_checks++;
    if (pad_oe_a !== 0 || pad_oe_b !== 0 || irq_a !== 0 || irq_b !== 0) begin
      n_fail++; $display("FAIL mid_reset_out: oe_a=%b oe_b=%b irq=%b%b want 0", pad_oe_a, pad_oe_b, irq_a, irq_b);
    end
    n_checks++;
    if (readdata_a !== 0 || readdata_b !== 0 || pad_out_b !== 2'b11) begin
      n_fail++; $display("FAIL mid_reset_regs: cap_a=%h cap_b=%h out_b=%b want 0 0 11", readdata_a, readdata_b, pad_out_b);
    end
    wr(1, 3);
    n_checks++;
    if (pad_oe_a !== 2'b00 || pad_oe_b !== 2'b11) begin n_fail++; $display("FAIL reset_data_oe: a=%b b=%b want 00 11", pad_oe_a, pad_oe_b); end
    wr(5, 1);
    n_checks++;
    if (pad_oe_a !== 2'b01 || pad_out_b !== 2'b10) begin n_fail++; $display("FAIL reset_data_clr: oe_a=%b out_b=%b want 01 10", pad_oe_a, pad_out_b); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(63) == 0);
      chipselect = $urandom_range(1);
      write_n = $urandom_range(1);
      address = 3'($urandom_range(7));
      writedata = $urandom;
      if ($urandom_range(3) == 0) pad_in = 2'($urandom);
      tick();
      n_checks++;
      if (pad_out_a !== 2'b00 || pad_oe_a !== (m_dir & ~m_data) || pad_out_b !== m_data || pad_oe_b !== m_dir) begin
        n_fail++; $display("FAIL rnd_drive[%0d]: a=%b/%b b=%b/%b want 00/%b %b/%b", i, pad_out_a, pad_oe_a, pad_out_b, pad_oe_b,
                           m_dir & ~m_data, m_data, m_dir);
      end
      n_checks++;
      if (irq_a !== |(m_cap_a & m_mask) || irq_b !== |(m_cap_b & m_mask)) begin
        n_fail++; $display("FAIL rnd_irq[%0d]: got %b%b want %b%b", i, irq_a, irq_b, |(m_cap_a & m_mask), |(m_cap_b & m_mask));
      end
      n_checks++;
      if (readdata_a !== exp_rd(address, m_cap_a) || readdata_b !== exp_rd(address, m_cap_b)) begin
        n_fail++; $display("FAIL rnd_read[%0d] addr %0d: got %h %h want %h %h", i, address, readdata_a, readdata_b,
                           exp_rd(address, m_cap_a), exp_rd(address, m_cap_b));
      end
    end
    reset = 0; chipselect = 0; write_n = 1;
  endtask

  initial begin
    test_reset();
    test_set_clr();
    test_edge_irq();
    test_set_wins();
    test_push_pull();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
